// File: rtl/alu_divider.sv
// alu_divider
//   Iterative restoring divider for the execute stage. It computes A / B and
//   A % B over a fixed number of cycles and hands the result back through a
//   start/busy/done handshake. The divZero and overflow flags use the same
//   style as the ALU flags, so the result can share the ALU writeback mux.
//
//   Build option: define DIV_SIGNED_EN to build signed support (magnitude
//   capture, result negation and the overflow flag). Without it, signedOp is
//   ignored, every divide is unsigned and overflow stays 0. Latency is the
//   same in both builds.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   start      divide request, sampled only while idle
//   signedOp   1 = two's-complement divide, 0 = unsigned
//   A, B       dividend and divisor, captured when start is accepted
//   Quotient   quotient, held until the next result is written
//   Remainder  remainder, held until the next result is written
//   busy       high while iterating and during the fix-up cycle
//   done       one-cycle pulse; results and flags are valid in this cycle
//   divZero    B was zero for this operation
//   overflow   signed 0x80000000 / -1
module alu_divider #(
  parameter int WIDTH = 32,
  parameter int ITERS = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signedOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             busy,
  output logic             done,
  output logic             divZero,
  output logic             overflow
);

  localparam int CW = $clog2(ITERS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvsr;
  logic [CW-1:0]    count;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic [WIDTH:0]   sh;
  logic [WIDTH-1:0] trial;
  logic             ge;

`ifdef DIV_SIGNED_EN
  logic a_neg;
  logic b_neg;
  logic qneg;
  logic rneg;
  logic ovf_pend;
  logic is_ovf;

  assign a_neg  = signedOp & A[WIDTH-1];
  assign b_neg  = signedOp & B[WIDTH-1];
  // -0x80000000 wraps to itself, which is the correct unsigned magnitude.
  assign a_mag  = a_neg ? -A : A;
  assign b_mag  = b_neg ? -B : B;
  assign is_ovf = signedOp && (A == {1'b1, {(WIDTH-1){1'b0}}}) && (B == '1);
  assign q_fix  = qneg ? -quo : quo;
  assign r_fix  = rneg ? -rem : rem;
`else
  logic unused_signedop;

  assign unused_signedop = signedOp;
  assign a_mag           = A;
  assign b_mag           = B;
  assign q_fix           = quo;
  assign r_fix           = rem;
`endif

  // One restoring step: the shifted partial remainder needs WIDTH+1 bits
  // because 2*rem+1 can exceed WIDTH bits when the divisor is large.
  always_comb begin
    sh    = {rem, quo[WIDTH-1]};
    ge    = (sh >= {1'b0, dvsr});
    trial = WIDTH'(sh - {1'b0, dvsr});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      rem       <= '0;
      quo       <= '0;
      dvsr      <= '0;
      count     <= '0;
      Quotient  <= '0;
      Remainder <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      divZero   <= 1'b0;
      overflow  <= 1'b0;
`ifdef DIV_SIGNED_EN
      qneg      <= 1'b0;
      rneg      <= 1'b0;
      ovf_pend  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (B == '0) begin
              Quotient  <= '1;
              Remainder <= A;
              divZero   <= 1'b1;
              overflow  <= 1'b0;
              done      <= 1'b1;
              state     <= S_DONE;
            end else begin
              rem      <= '0;
              quo      <= a_mag;
              dvsr     <= b_mag;
              count    <= '0;
              divZero  <= 1'b0;
              overflow <= 1'b0;
              busy     <= 1'b1;
              state    <= S_RUN;
`ifdef DIV_SIGNED_EN
              qneg     <= a_neg ^ b_neg;
              rneg     <= a_neg;
              ovf_pend <= is_ovf;
`endif
            end
          end
        end

        S_RUN: begin
          if (ge) begin
            rem <= trial;
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= sh[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
          count <= count + 1'b1;
          if (count == CW'(ITERS - 1)) begin
            state <= S_FIX;
          end
        end

        S_FIX: begin
          Quotient  <= q_fix;
          Remainder <= r_fix;
`ifdef DIV_SIGNED_EN
          overflow  <= ovf_pend;
`endif
          busy      <= 1'b0;
          done      <= 1'b1;
          state     <= S_DONE;
        end

        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_divider.sv
module tb_alu_divider;

`ifdef DIV_SIGNED_EN
  localparam bit SGN_EN = 1'b1;
`else
  localparam bit SGN_EN = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    logic        ov;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic        signedOp;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] Quotient;
  logic [31:0] Remainder;
  logic        busy;
  logic        done;
  logic        divZero;
  logic        overflow;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  alu_divider #(.WIDTH(32), .ITERS(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .signedOp  (signedOp),
    .A         (A),
    .B         (B),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .busy      (busy),
    .done      (done),
    .divZero   (divZero),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t e;
    e.dz = 1'b0;
    e.ov = 1'b0;
    if (b == 32'd0) begin
      e.q  = '1;
      e.r  = a;
      e.dz = 1'b1;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q  = 32'h8000_0000;
      e.r  = 32'd0;
      e.ov = 1'b1;
    end else if (s) begin
      e.q = $signed(a) / $signed(b);
      e.r = $signed(a) % $signed(b);
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  // Drives one divide and watches 60 cycles. poke_at re-asserts start with
  // other operands; rst_at pulses reset mid-operation (no result expected).
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input exp_t e, input int exp_lat,
                       input int poke_at, input int rst_at);
    int   lat      = 0;
    int   done_cnt = 0;
    int   busy_cyc = 0;
    exp_t got;
    if (rst_at == 0) sb.push_back(e);
    @(negedge clk);
    A        = a;
    B        = b;
    signedOp = s;
    start    = 1'b1;
    @(posedge clk);
    while (lat < 60) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        start = 1'b0;
        A     = ~a;
        B     = $urandom;
      end
      if (poke_at != 0 && lat == poke_at) begin
        start = 1'b1;
        A     = 32'h1234_5678;
        B     = 32'd3;
      end
      if (poke_at != 0 && lat == poke_at + 1) start = 1'b0;
      if (rst_at != 0 && lat == rst_at) reset = 1'b1;
      if (rst_at != 0 && lat == rst_at + 1) begin
        reset = 1'b0;
        check({tag, "_rst_q"}, Quotient, 32'd0);
        check({tag, "_rst_r"}, Remainder, 32'd0);
        check({tag, "_rst_busy"}, 32'(busy), 32'd0);
        check({tag, "_rst_done"}, 32'(done), 32'd0);
        check({tag, "_rst_dz"}, 32'(divZero), 32'd0);
        check({tag, "_rst_ov"}, 32'(overflow), 32'd0);
      end
      if (busy) busy_cyc++;
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
          check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
          if (sb.size() > 0) begin
            got = sb.pop_front();
            check({tag, "_q"}, Quotient, got.q);
            check({tag, "_r"}, Remainder, got.r);
            check({tag, "_dz"}, 32'(divZero), 32'(got.dz));
            check({tag, "_ov"}, 32'(overflow), 32'(got.ov));
          end
        end
      end
    end
    check({tag, "_done_count"}, 32'(done_cnt), (rst_at != 0) ? 32'd0 : 32'd1);
    check({tag, "_busy_cycles"}, 32'(busy_cyc),
          (rst_at != 0) ? 32'(rst_at) : 32'(exp_lat - 1));
  endtask

  initial begin
    exp_t        e;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;

    reset    = 1'b1;
    start    = 1'b0;
    signedOp = 1'b0;
    A        = '0;
    B        = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_q", Quotient, 32'd0);
    check("reset_r", Remainder, 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_dz", 32'(divZero), 32'd0);
    check("reset_ov", 32'(overflow), 32'd0);
    reset = 1'b0;

    e = '{q: 32'd14, r: 32'd2, dz: 1'b0, ov: 1'b0};
    do_op("unsigned_100_7", 32'd100, 32'd7, 1'b0, e, 34, 0, 0);

    if (SGN_EN) e = '{q: 32'hFFFF_FFFD, r: 32'hFFFF_FFFF, dz: 1'b0, ov: 1'b0};
    else        e = '{q: 32'h7FFF_FFFC, r: 32'd1, dz: 1'b0, ov: 1'b0};
    do_op("signed_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, e, 34, 0, 0);

    e = '{q: 32'h7FFF_FFFC, r: 32'd1, dz: 1'b0, ov: 1'b0};
    do_op("unsigned_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b0, e, 34, 0, 0);

    e = '{q: 32'hFFFF_FFFF, r: 32'd1234, dz: 1'b1, ov: 1'b0};
    do_op("div_zero", 32'd1234, 32'd0, 1'b0, e, 1, 0, 0);

    if (SGN_EN) e = '{q: 32'h8000_0000, r: 32'd0, dz: 1'b0, ov: 1'b1};
    else        e = '{q: 32'd0, r: 32'h8000_0000, dz: 1'b0, ov: 1'b0};
    do_op("signed_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, e, 34, 0, 0);

    e = '{q: 32'd100, r: 32'd0, dz: 1'b0, ov: 1'b0};
    do_op("handshake", 32'd1000, 32'd10, 1'b0, e, 34, 10, 0);

    e = '{q: 32'd0, r: 32'd0, dz: 1'b0, ov: 1'b0};
    do_op("reset_mid_run", 32'd5000, 32'd3, 1'b0, e, 34, 0, 15);

    e = '{q: 32'h0FFF_FFFF, r: 32'h0000_000F, dz: 1'b0, ov: 1'b0};
    do_op("after_reset", 32'hFFFF_FFFF, 32'h0000_0010, 1'b0, e, 34, 0, 0);

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom;
      rb = rb >> $urandom_range(0, 31);
      rs = 1'($urandom_range(0, 1));
      e  = model(ra, rb, rs & SGN_EN);
      do_op("random", ra, rb, rs, e, (rb == 32'd0) ? 1 : 34, 0, 0);
    end

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
